phase_timer_bank: RTL and testbench

- Parametrised, multi-channel replacement for the per-phase hard-coded rate dividers and `done_*` comparators in the battle top level.
- One shared down-time engine runs one drawing/message phase at a time. Each channel's phase length comes from a run-time-writable length table.
- While a phase runs, the block outputs an ascending pixel/step offset and an optional pause. At the end it emits a single-cycle done pulse tagged with the channel.
- The control FSM issues start requests through a valid/ready handshake instead of wiring ten separate enables.

---
 rtl/phase_timer_bank_if.sv | 41 ++++
 rtl/phase_timer_bank.sv | 144 ++++++++++++++
 tb/tb_phase_timer_bank.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/phase_timer_bank_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : phase_timer_bank_if
//  Description : Bundle of the phase-timer configuration, start handshake,
//                run control and status signals.
//                master : controller side (drives cfg/start/pause/abort)
//                slave  : timer bank side (drives ready/busy/offset/pulses)
//  Revision    : 1.0 - initial release
// ============================================================================
interface phase_timer_bank_if #(
    parameter int CNT_W = 26,
    parameter int SEL_W = 4
) ();
    logic             cfg_we;
    logic [SEL_W-1:0] cfg_sel;
    logic [CNT_W-1:0] cfg_val;
    logic             start_valid;
    logic [SEL_W-1:0] start_sel;
    logic             start_ready;
    logic             pause;
    logic             abort;
    logic             busy;
    logic [SEL_W-1:0] active_ch;
    logic [CNT_W-1:0] offset;
    logic             done;
    logic [SEL_W-1:0] done_ch;
    logic             aborted;
    logic             sel_err;

    modport master (
        output cfg_we, cfg_sel, cfg_val, start_valid, start_sel, pause, abort,
        input  start_ready, busy, active_ch, offset, done, done_ch, aborted, sel_err
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_val, start_valid, start_sel, pause, abort,
        output start_ready, busy, active_ch, offset, done, done_ch, aborted, sel_err
    );
endinterface
`default_nettype wire

// File: rtl/phase_timer_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : phase_timer_bank
//  Description : Shared phase-duration engine. A run-time writable length
//                table holds one phase length per channel; a started phase
//                counts an ascending offset 0..len (freezable by pause), then
//                emits a one-cycle done pulse tagged with the channel.
//  Ports       : clk, reset (sync, active-high)
//                bus (slave) : cfg_we/cfg_sel/cfg_val table write,
//                              start_valid/start_sel/start_ready handshake,
//                              pause, abort, busy, active_ch, offset,
//                              done/done_ch, aborted, sel_err pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_timer_bank #(
    parameter int               NCH         = 10,
    parameter int               CNT_W       = 26,
    parameter int               SEL_W       = 4,
    parameter logic [CNT_W-1:0] DEFAULT_LEN = 'h00FFFF
) (
    input  wire logic            clk,
    input  wire logic            reset,
    phase_timer_bank_if.slave    bus
);

    localparam logic [SEL_W:0]   c_NCH = NCH[SEL_W:0];
    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_len_tbl [NCH];
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] w_len_next;
    logic [CNT_W-1:0] r_offset;
    logic [CNT_W-1:0] w_offset_next;
    logic [SEL_W-1:0] r_active_ch;
    logic [SEL_W-1:0] w_active_next;
    logic [SEL_W-1:0] r_done_ch;
    logic             r_done;
    logic             r_aborted;
    logic             r_sel_err;
    logic             w_done_set;
    logic             w_abort_set;
    logic             w_start_bad;
    logic             w_sel_err_set;
    logic             w_cfg_ok;
    logic             w_start_ok;

    assign w_cfg_ok   = ({1'b0, bus.cfg_sel}   < c_NCH);
    assign w_start_ok = ({1'b0, bus.start_sel} < c_NCH);

    always_comb begin
        w_state_next  = r_state;
        w_len_next    = r_len;
        w_offset_next = r_offset;
        w_active_next = r_active_ch;
        w_done_set    = 1'b0;
        w_abort_set   = 1'b0;
        w_start_bad   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start_valid) begin
                    if (w_start_ok) begin
                        // Table read sees the pre-edge value, so a same-edge
                        // cfg write to this channel only affects later starts.
                        w_state_next  = S_RUN;
                        w_len_next    = r_len_tbl[bus.start_sel];
                        w_active_next = bus.start_sel;
                        w_offset_next = '0;
                    end else begin
                        w_start_bad = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // Abort outranks both pause and the terminal step.
                if (bus.abort) begin
                    w_state_next  = S_IDLE;
                    w_offset_next = '0;
                    w_abort_set   = 1'b1;
                end else if (!bus.pause) begin
                    if (r_offset == r_len) begin
                        w_state_next = S_IDLE;
                        w_done_set   = 1'b1;
                    end else begin
                        w_offset_next = r_offset + c_ONE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        // Status pulses are mutually exclusive: a phase ending or being
        // aborted on the same edge as an illegal select masks the error pulse.
        w_sel_err_set = ((bus.cfg_we && !w_cfg_ok) || w_start_bad)
                        && !w_done_set && !w_abort_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_offset    <= '0;
            r_active_ch <= '0;
            r_done_ch   <= '0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_sel_err   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                r_len_tbl[i] <= DEFAULT_LEN;
            end
        end else begin
            r_state     <= w_state_next;
            r_len       <= w_len_next;
            r_offset    <= w_offset_next;
            r_active_ch <= w_active_next;
            r_done      <= w_done_set;
            r_aborted   <= w_abort_set;
            r_sel_err   <= w_sel_err_set;
            if (w_done_set) begin
                r_done_ch <= r_active_ch;
            end
            if (bus.cfg_we && w_cfg_ok) begin
                r_len_tbl[bus.cfg_sel] <= bus.cfg_val;
            end
        end
    end

    assign bus.start_ready = (r_state == S_IDLE);
    assign bus.busy        = (r_state == S_RUN);
    assign bus.active_ch   = r_active_ch;
    assign bus.offset      = r_offset;
    assign bus.done        = r_done;
    assign bus.done_ch     = r_done_ch;
    assign bus.aborted     = r_aborted;
    assign bus.sel_err     = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_phase_timer_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_phase_timer_bank
//  Description : Self-checking bench for phase_timer_bank. A phase-level
//                reference model predicts status pulses into a queue that a
//                monitor drains and compares; per-cycle status is compared
//                against the model's view of the running phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_timer_bank;

    localparam int NCH     = 10;
    localparam int CNT_W   = 26;
    localparam int SEL_W   = 4;
    localparam int DEF_LEN = 65535;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    phase_timer_bank_if #(.CNT_W(CNT_W), .SEL_W(SEL_W)) bus ();

    phase_timer_bank #(
        .NCH(NCH), .CNT_W(CNT_W), .SEL_W(SEL_W), .DEFAULT_LEN(26'h00FFFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // ---------------- reference model (phase level) ----------------
    typedef struct {
        bit [2:0] ev;    // {done, aborted, sel_err}
        int       ch;
        longint   due;
    } exp_t;

    exp_t   q_exp[$];
    int     m_tbl [16];
    bit     m_run   = 0;
    int     m_ch    = 0;
    int     m_len   = 0;
    int     m_steps = 0;   // unpaused edges seen since the phase began
    int     m_off   = 0;
    bit     m_live  = 0;
    bit     m_rst   = 0;
    longint m_cyc   = 0;

    always @(posedge clk) begin
        bit [2:0] ev;
        int       ech;
        bit       bad;
        m_cyc++;
        if (reset) begin
            m_run = 0; m_ch = 0; m_len = 0; m_steps = 0; m_off = 0;
            for (int i = 0; i < 16; i++) m_tbl[i] = DEF_LEN;
            q_exp.delete();
            m_live = 1;
            m_rst  = 1;
        end else if (m_live) begin
            m_rst = 0;
            ev = 3'b000; ech = 0; bad = 0;
            if (m_run) begin
                if (bus.abort) begin
                    m_run = 0; m_off = 0; ev = 3'b010;
                end else if (!bus.pause) begin
                    m_steps++;
                    // Phase lasts len+1 unpaused cycles; offset saturates at len.
                    if (m_steps > m_len) begin
                        m_run = 0; ev = 3'b100; ech = m_ch; m_off = m_len;
                    end else begin
                        m_off = m_steps;
                    end
                end
            end else if (bus.start_valid) begin
                if (int'(bus.start_sel) < NCH) begin
                    m_run = 1; m_ch = int'(bus.start_sel);
                    m_len = m_tbl[m_ch]; m_steps = 0; m_off = 0;
                end else begin
                    bad = 1;
                end
            end
            if (bus.cfg_we && int'(bus.cfg_sel) >= NCH) bad = 1;
            if (bad && ev == 3'b000) ev = 3'b001;
            if (bus.cfg_we && int'(bus.cfg_sel) < NCH)
                m_tbl[int'(bus.cfg_sel)] = int'(bus.cfg_val);
            if (ev != 3'b000) q_exp.push_back('{ev: ev, ch: ech, due: m_cyc});
        end
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic check(input string name, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, m_cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t     e;
        bit [2:0] got;
        if (m_live) begin
            e   = '{ev: 3'b000, ch: 0, due: 0};
            got = {bus.done, bus.aborted, bus.sel_err};
            if (q_exp.size() > 0 && q_exp[0].due == m_cyc) e = q_exp.pop_front();
            if (got != 3'b000 || e.ev != 3'b000) check("pulses", got, e.ev);
            if (e.ev[2]) check("done_ch", bus.done_ch, e.ch);
            if (m_rst) check("done_ch_rst", bus.done_ch, 0);
            check("busy", bus.busy, m_run);
            check("start_ready", bus.start_ready, !m_run);
            check("offset", bus.offset, m_off);
            check("active_ch", bus.active_ch, m_ch);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit we, input int csel, input int cval,
                        input bit sv, input int ssel,
                        input bit p, input bit a, input bit r);
        bus.cfg_we      = we;
        bus.cfg_sel     = SEL_W'(csel);
        bus.cfg_val     = CNT_W'(cval);
        bus.start_valid = sv;
        bus.start_sel   = SEL_W'(ssel);
        bus.pause       = p;
        bus.abort       = a;
        reset           = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input int ch, input int len);
        step(1, ch, len, 0, 0, 0, 0, 0);
    endtask

    task automatic start(input int ch);
        step(0, 0, 0, 1, ch, 0, 0, 0);
    endtask

    // Advance until the DUT shows done; expiry counts as a failure.
    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (!bus.done && k < budget) begin
            idle(1);
            k++;
        end
        n_chk++;
        if (!bus.done) begin
            n_err++;
            $display("FAIL %s: no done within %0d cycles", name, budget);
        end
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);

        // basic phase: ch3 len 5
        cfg(3, 5);
        start(3);
        idle(8);

        // default length on ch0, back-to-back start of ch1 in the done cycle
        start(0);
        wait_done("default_len", DEF_LEN + 10);
        start(1);
        idle(6);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        idle(3);

        // pause for 3 cycles at offset 2
        cfg(4, 4);
        start(4);
        idle(2);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0, 0);
        wait_done("pause_run", 20);
        idle(2);

        // abort at offset 3
        start(4);
        idle(3);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        idle(8);

        // same-edge cfg write and start, then start while busy
        cfg(2, 2);
        step(1, 2, 9, 1, 2, 0, 0, 0);
        idle(5);
        start(2);
        idle(2);
        start(4);
        idle(12);

        // len = 0, illegal selects, pause on terminal cycle
        cfg(5, 0);
        start(5);
        idle(3);
        start(12);
        idle(1);
        step(1, 13, 7, 0, 0, 0, 0, 0);
        idle(2);
        cfg(6, 1);
        start(6);
        idle(1);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 1, 0, 0);
        idle(3);

        // reset mid-run: table must revert so ch3 no longer ends at 5
        start(3);
        idle(2);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        start(3);
        idle(200);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);

        // randomized traffic with short lengths
        for (int i = 0; i < NCH; i++) cfg(i, $urandom_range(0, 12));
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 99) < 10, $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 99) < 25, $urandom_range(0, 15),
                 $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 999) < 3);
        end
        step(0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);

        n_chk++;
        if (q_exp.size() != 0) begin
            n_err++;
            $display("FAIL leftover_events: got %0d pending expected 0", q_exp.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
